softmax_max_sub: RTL and testbench
==================================

// Module: softmax_max_sub
// PURPOSE
//   Softmax input stage that sits directly upstream of the vectorized exp block.
//   Buffers one row of TILE_SIZE-lane Q(WIDTH-FRAC).FRAC tiles and tracks the row maximum while filling.
//   Replays the row as X_i - max(row), so every value fed to exp is <= 0 (numerically stable softmax).
//   Flattened tiles: most-significant chunk = element 0.
// PARAMETERS
//   WIDTH      32  element bit width, signed two's complement
//   FRAC       16  fractional bits; pass-through only, the subtraction is format-agnostic
//   TILE_SIZE  4   lanes per tile
//   ROW_TILES  8   maximum tiles per row, which is also the buffer depth (>=2)
// PORTS
//   CLK        in   1                clock, rising edge
//   RST_N      in   1                asynchronous active-low reset
//   in_valid   in   1                input tile valid
//   in_ready   out  1                stage can accept a tile
//   in_data    in   TILE_SIZE*WIDTH  input tile, signed lanes
//   in_last    in   1                this tile is the last tile of the row
//   out_valid  out  1                output tile valid
//   out_ready  in   1                downstream accepts the output tile
//   out_data   out  TILE_SIZE*WIDTH  X_i - row_max per lane, saturated
//   out_last   out  1                last tile of the row
//   row_max    out  WIDTH            maximum of the current row; stable while in DRAIN
// BEHAVIOUR
//   - Handshake: a transfer occurs on a cycle with valid && ready.
//     - valid must not depend on ready.
//     - Data must be held stable while valid && !ready.
//   - FSM has two states, FILL and DRAIN.
//     - in_ready = (state==FILL).
//     - out_valid = (state==DRAIN).
//     - There is no overlap between filling and draining (single buffer).
//   - FILL, on each accepted tile:
//     - buf[wr_ptr] <= in_data; wr_ptr++.
//     - max_r <= max(max_r, all lanes of in_data), signed compare.
//     - The row ends on an accepted tile with in_last=1, or on the accepted tile where wr_ptr==ROW_TILES-1.
//       A forced end (no in_last) sets the sticky internal flag len_err; a bench can probe it.
//     - At row end: row_len <= wr_ptr+1, rd_ptr <= 0, state <= DRAIN.
//       The max update from that last tile is included.
//   - DRAIN:
//     - out_data lane k = sat(buf[rd_ptr][k] - max_r).
//     - out_last = (rd_ptr == row_len-1).
//     - On an output transfer: rd_ptr++.
//     - On the transfer with out_last: state <= FILL, wr_ptr <= 0, max_r <= most negative value (1 followed by WIDTH-1 zeros).
//   - Latency: out_valid rises the cycle after the final input tile is accepted.
//     Back-to-back rows cost 1 cycle of in_ready=1 gap between the final output and the next output row (minimum).
//   - Arithmetic: compute the difference in WIDTH+1 bits.
//     - Results below -2^(WIDTH-1) clamp to the most negative value.
//     - The result is never positive (max_r >= every lane).
//     - Lanes equal to max_r yield exactly 0.
//   - out_data, out_last and row_max are driven from registered state (buffer, rd_ptr, max_r) only.
//     There is no combinational path from in_* to out_*.
//   - Reset (asynchronous, any time, including mid-fill or mid-drain):
//     - state=FILL; wr_ptr=rd_ptr=row_len=0.
//     - max_r = most negative value; len_err=0.
//     - After reset: out_valid=0, out_last=0, in_ready=1.
//     - Buffered data is discarded. Buffer contents are not reset and need none.
//   - Single-tile row (in_last on the first tile): DRAIN emits 1 tile with out_last=1.
//   - out_ready held low in DRAIN: out_data and out_last hold; in_ready stays 0.
// TESTING
//   1. TILE_SIZE=4, 1-tile row with lanes {1.0,2.0,-1.0,0.5} (0x00010000,0x00020000,0xFFFF0000,0x00008000), in_last=1
//      -> row_max=0x00020000; out {0xFFFF0000,0x00000000,0xFFFD0000,0xFFFE8000}; out_last=1.
//   2. 3-tile row where max 5.0 sits in tile 2 lane 3, other lanes 0 -> 3 outputs in input order.
//      The max lane gives 0; all other lanes give 0xFFFB0000; out_last only on the 3rd tile.
//   3. Saturation: lanes {0x7FFFFFFF,0x80000000,0,0}
//      -> out {0,0x80000000 (clamped),0x80000001,0x80000001}.
//   4. Random out_ready backpressure (50%) plus random in_valid gaps over 200 rows of random length 1..ROW_TILES
//      -> outputs match a reference model tile-for-tile; no data changes while stalled.
//   5. ROW_TILES=8 tiles with no in_last -> row ends after the 8th tile; len_err=1; 8 outputs, last flagged.
//   6. Assert RST_N=0 after 3 outputs of a 5-tile drain -> out_valid=0 immediately, in_ready=1 after release.
//      The next row's max is not affected by the aborted row.

Source files
------------

// File: rtl/softmax_max_sub.sv
// Softmax input stage: buffers one row of tiles while tracking the row maximum,
// then replays each lane as a saturated (x - row_max), so the values fed to exp are <= 0.
module softmax_max_sub #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC      = 16,
  parameter int unsigned TILE_SIZE = 4,
  parameter int unsigned ROW_TILES = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TILE_SIZE*WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TILE_SIZE*WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic [WIDTH-1:0]           row_max
);

  localparam int unsigned TW = TILE_SIZE * WIDTH;
  localparam int unsigned PW = $clog2(ROW_TILES);
  localparam int unsigned LW = $clog2(ROW_TILES + 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  // The subtraction is format-agnostic; FRAC only has to describe a legal format.
  if (FRAC > WIDTH) begin : g_frac_check
    $error("FRAC must not exceed WIDTH");
  end

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     row_len_q, row_len_d;
  logic [WIDTH-1:0]  max_q, max_d;
  logic              len_err, len_err_d;
  logic [TW-1:0]     buf_q [ROW_TILES];

  logic              in_fire, out_fire, row_end;
  logic [WIDTH-1:0]  tile_max;
  logic [TW-1:0]     tile_rd;
  logic [WIDTH:0]    diff;

  assign in_ready  = (state_q == StFill);
  assign out_valid = (state_q == StDrain);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // A full buffer closes the row even without in_last.
  assign row_end   = in_fire && (in_last || (wr_ptr_q == PW'(ROW_TILES - 1)));
  assign tile_rd   = buf_q[rd_ptr_q];
  assign out_last  = out_valid && (LW'(rd_ptr_q) == row_len_q - LW'(1));
  assign row_max   = max_q;

  always_comb begin
    tile_max = max_q;
    for (int k = 0; k < TILE_SIZE; k++) begin
      if ($signed(in_data[k*WIDTH +: WIDTH]) > $signed(tile_max)) begin
        tile_max = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Difference in WIDTH+1 bits, then clamp on overflow.
  always_comb begin
    out_data = '0;
    diff     = '0;
    for (int k = 0; k < TILE_SIZE; k++) begin
      diff = {tile_rd[k*WIDTH + WIDTH - 1], tile_rd[k*WIDTH +: WIDTH]}
           - {max_q[WIDTH-1], max_q};
      if (diff[WIDTH] && !diff[WIDTH-1]) begin
        out_data[k*WIDTH +: WIDTH] = MinVal;
      end else if (!diff[WIDTH] && diff[WIDTH-1]) begin
        out_data[k*WIDTH +: WIDTH] = ~MinVal;
      end else begin
        out_data[k*WIDTH +: WIDTH] = diff[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    row_len_d = row_len_q;
    max_d     = max_q;
    len_err_d = len_err;
    unique case (state_q)
      StFill: begin
        if (in_fire) begin
          max_d = tile_max;
          if (row_end) begin
            row_len_d = LW'(wr_ptr_q) + LW'(1);
            rd_ptr_d  = '0;
            state_d   = StDrain;
            if (!in_last) len_err_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end
      end
      StDrain: begin
        if (out_fire) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (out_last) begin
            state_d  = StFill;
            wr_ptr_d = '0;
            max_d    = MinVal;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StFill;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      row_len_q <= '0;
      max_q     <= MinVal;
      len_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      row_len_q <= row_len_d;
      max_q     <= max_d;
      len_err   <= len_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (in_fire) buf_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_softmax_max_sub.sv
// Bench for softmax_max_sub: directed rows plus randomized rows with backpressure,
// checked against a plain-arithmetic row-max / subtract-and-clamp model.
module tb_softmax_max_sub;

  localparam int W  = 32;
  localparam int TS = 4;
  localparam int RT = 8;
  localparam int TW = TS * W;

  typedef logic [TW-1:0] tile_t;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  tile_t         in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  tile_t         out_data;
  logic          out_last;
  logic [W-1:0]  row_max;

  int n_vec = 0;
  int n_err = 0;

  softmax_max_sub #(.WIDTH(W), .FRAC(16), .TILE_SIZE(TS), .ROW_TILES(RT)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .row_max   (row_max)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] ref_max(input tile_t q[$]);
    longint mx = -(longint'(1) << (W - 1));
    foreach (q[i]) begin
      tile_t t = q[i];
      for (int k = 0; k < TS; k++) begin
        longint v = longint'($signed(t[k*W +: W]));
        if (v > mx) mx = v;
      end
    end
    return mx[W-1:0];
  endfunction

  function automatic tile_t ref_out(input tile_t t, input logic [W-1:0] m);
    tile_t  r;
    longint lo = -(longint'(1) << (W - 1));
    for (int k = 0; k < TS; k++) begin
      longint d = longint'($signed(t[k*W +: W])) - longint'($signed(m));
      if (d < lo) d = lo;
      r[k*W +: W] = d[W-1:0];
    end
    return r;
  endfunction

  // Runs aligned to 1 time unit after a rising edge.
  task automatic put_tile(input tile_t d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(posedge CLK); #1; n++;
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL put_tile_timeout: in_ready=%b required 1", in_ready);
    end else begin
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drive_row(input tile_t q[$], input bit use_last, input int max_gap);
    foreach (q[i]) begin
      repeat ($urandom_range(max_gap)) begin
        @(posedge CLK); #1;
      end
      put_tile(q[i], use_last && (i == q.size() - 1));
    end
  endtask

  task automatic drain_check(input string name, input tile_t q[$], input int stall_pct,
                             output tile_t got[$]);
    logic [W-1:0] m = ref_max(q);
    int idx = 0;
    int cyc = 0;
    got = {};
    while (!out_valid && cyc < 200) begin
      @(posedge CLK); #1; cyc++;
    end
    n_vec++;
    if (!out_valid) begin
      n_err++;
      $display("FAIL %s_valid_timeout: out_valid=%b required 1", name, out_valid);
      return;
    end
    n_vec++;
    if (row_max !== m) begin
      n_err++;
      $display("FAIL %s_row_max: got %h required %h", name, row_max, m);
    end
    while (idx < q.size() && cyc < 5000) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      n_vec++;
      if (!out_valid || in_ready) begin
        n_err++;
        $display("FAIL %s_drain_state: out_valid=%b in_ready=%b required 1/0",
                 name, out_valid, in_ready);
      end else if (out_data !== ref_out(q[idx], m) || out_last !== (idx == q.size() - 1)) begin
        n_err++;
        $display("FAIL %s_tile%0d: got %h last=%b required %h last=%b", name, idx,
                 out_data, out_last, ref_out(q[idx], m), (idx == q.size() - 1));
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        idx++;
      end
      @(posedge CLK); #1; cyc++;
    end
    out_ready = 1'b0;
    n_vec++;
    if (idx < q.size() || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_row_done: tiles=%0d out_valid=%b in_ready=%b required %0d/0/1",
               name, idx, out_valid, in_ready, q.size());
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_reset: valid/last/ready=%b%b%b required 001",
               out_valid, out_last, in_ready);
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;
    n_vec++;
    if (row_max !== 32'h8000_0000 || dut.len_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: row_max=%h len_err=%b required 80000000/0",
               row_max, dut.len_err);
    end
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_tile;
    tile_t q[$];
    tile_t got[$];
    tile_t want = {32'hFFFF_0000, 32'h0000_0000, 32'hFFFD_0000, 32'hFFFE_8000};
    q = '{{32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000}};
    drive_row(q, 1'b1, 0);
    n_vec++;
    if (out_valid !== 1'b1 || row_max !== 32'h0002_0000) begin
      n_err++;
      $display("FAIL single_latency_max: out_valid=%b row_max=%h required 1/00020000",
               out_valid, row_max);
    end
    drain_check("single", q, 0, got);
    n_vec++;
    if (got.size() != 1 || got[0] !== want) begin
      n_err++;
      $display("FAIL single_value: got %0d tiles first %h required 1 tile %h",
               got.size(), (got.size() > 0) ? got[0] : '0, want);
    end
  endtask

  task automatic test_multi_tile;
    tile_t q[$];
    tile_t got[$];
    tile_t fill5 = {4{32'hFFFB_0000}};
    tile_t last5 = {32'hFFFB_0000, 32'hFFFB_0000, 32'hFFFB_0000, 32'h0000_0000};
    q = '{tile_t'(0), tile_t'(0), {32'h0, 32'h0, 32'h0, 32'h0005_0000}};
    drive_row(q, 1'b1, 1);
    drain_check("three", q, 30, got);
    n_vec++;
    if (got.size() != 3 || got[0] !== fill5 || got[1] !== fill5 || got[2] !== last5) begin
      n_err++;
      $display("FAIL three_values: got %0d tiles, last %h required 3 tiles, last %h",
               got.size(), (got.size() > 2) ? got[2] : '0, last5);
    end
  endtask

  task automatic test_saturation;
    tile_t q[$];
    tile_t got[$];
    tile_t want = {32'h0000_0000, 32'h8000_0000, 32'h8000_0001, 32'h8000_0001};
    q = '{{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0}};
    drive_row(q, 1'b1, 0);
    drain_check("sat", q, 0, got);
    n_vec++;
    if (got.size() != 1 || got[0] !== want) begin
      n_err++;
      $display("FAIL sat_value: got %h required %h", (got.size() > 0) ? got[0] : '0, want);
    end
    n_vec++;
    if (dut.len_err !== 1'b0) begin
      n_err++;
      $display("FAIL len_err_clear: got %b required 0", dut.len_err);
    end
  endtask

  task automatic test_forced_end;
    tile_t q[$];
    tile_t got[$];
    for (int i = 0; i < RT; i++) q.push_back({$urandom, $urandom, $urandom, $urandom});
    drive_row(q, 1'b0, 1);
    n_vec++;
    if (dut.len_err !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL forced_end: len_err=%b out_valid=%b required 1/1", dut.len_err, out_valid);
    end
    drain_check("forced", q, 25, got);
    n_vec++;
    if (got.size() != RT) begin
      n_err++;
      $display("FAIL forced_count: got %0d tiles required %0d", got.size(), RT);
    end
  endtask

  task automatic test_reset_mid_drain;
    tile_t q[$];
    tile_t got[$];
    for (int i = 0; i < 5; i++) q.push_back({32'h7FFF_0000, 32'h0, 32'h1234_0000, 32'h0});
    drive_row(q, 1'b1, 0);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pre: out_valid=%b out_last=%b required 1/0", out_valid, out_last);
    end
    RST_N = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_async: valid/last/ready=%b%b%b required 001",
               out_valid, out_last, in_ready);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    n_vec++;
    if (in_ready !== 1'b1 || dut.len_err !== 1'b0) begin
      n_err++;
      $display("FAIL abort_release: in_ready=%b len_err=%b required 1/0", in_ready, dut.len_err);
    end
    q = '{{4{32'hFFFB_0000}}, {32'hFFF6_0000, 32'hFFFB_0000, 32'hFFF0_0000, 32'hFFF6_0000}};
    drive_row(q, 1'b1, 0);
    n_vec++;
    if (row_max !== 32'hFFFB_0000) begin
      n_err++;
      $display("FAIL abort_next_max: got %h required fffb0000", row_max);
    end
    drain_check("post_abort", q, 0, got);
  endtask

  task automatic test_random;
    for (int r = 0; r < 200; r++) begin
      tile_t q[$];
      tile_t got[$];
      int    len = $urandom_range(RT, 1);
      bit    use_last = (len < RT) ? 1'b1 : 1'($urandom_range(1));
      for (int i = 0; i < len; i++) begin
        tile_t t;
        for (int k = 0; k < TS; k++) begin
          logic [W-1:0] v = $urandom;
          if ($urandom_range(1) == 1) v = {{16{v[15]}}, v[15:0]};
          t[k*W +: W] = v;
        end
        q.push_back(t);
      end
      drive_row(q, use_last, 2);
      drain_check("rand", q, 50, got);
    end
  endtask

  initial begin
    test_reset;
    test_single_tile;
    test_multi_tile;
    test_saturation;
    test_forced_end;
    test_reset_mid_drain;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
